// File: rtl/key_matrix_emu_if.sv
// Command channel of the key matrix emulator: press requests in, status out.
interface key_matrix_emu_if;
  logic        Cmd_Valid;
  logic        Cmd_Ready;
  logic [3:0]  Cmd_Key;
  logic [15:0] Cmd_Hold;
  logic        Busy;
  logic        Done;

  modport master (output Cmd_Valid, Cmd_Key, Cmd_Hold, input Cmd_Ready, Busy, Done);
  modport slave  (input Cmd_Valid, Cmd_Key, Cmd_Hold, output Cmd_Ready, Busy, Done);
endinterface

// File: rtl/key_matrix_emu.sv
// Emulates one key of a 4x4 scanned keypad: bounced press, timed hold,
// bounced release and a quiet gap, driven by press commands.
module key_matrix_emu #(
  parameter int TICK_CYC       = 50000,
  parameter int BOUNCE_CYC     = 1000,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int GAP_TICKS      = 30
) (
  input  logic             Clk,
  input  logic             Rst,
  key_matrix_emu_if.slave  cmd,
  input  logic [3:0]       Key_Board_Col_i,
  output logic [3:0]       Key_Board_Row_o
);

  localparam int CNT_MAX = (TICK_CYC > BOUNCE_CYC) ? TICK_CYC : BOUNCE_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TOG_W   = (BOUNCE_TOGGLES > 0) ? $clog2(BOUNCE_TOGGLES + 1) : 1;
  localparam logic [CW-1:0]    TICK_LAST   = CW'(TICK_CYC - 1);
  localparam logic [CW-1:0]    BOUNCE_LAST = CW'(BOUNCE_CYC - 1);
  localparam logic [TOG_W-1:0] TOG_N       = TOG_W'(BOUNCE_TOGGLES);
  localparam logic [15:0]      GAP_LAST    = 16'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    BOUNCE_P = 3'd1,
    HOLD     = 3'd2,
    BOUNCE_R = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t           state_r, state_nx_s;
  logic             contact_r, contact_nx_s;
  logic [CW-1:0]    cyc_r, cyc_nx_s;
  logic [15:0]      tick_r, tick_nx_s;
  logic [TOG_W-1:0] tog_r, tog_nx_s;
  logic [1:0]       row_r, col_r;
  logic [15:0]      hold_last_r;
  logic             ready_r, busy_r, done_r;
  logic             accept_s;

  // Key code to {row, col}; codes 0 and 10 sit off the linear order.
  function automatic logic [3:0] key_pos(input logic [3:0] key);
    case (key)
      4'd0:    key_pos = 4'd9;
      4'd10:   key_pos = 4'd15;
      4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
      4'd11, 4'd12, 4'd13, 4'd14, 4'd15:
               key_pos = key - 4'd1;
      default: key_pos = 4'd0;
    endcase
  endfunction

  assign cmd.Cmd_Ready = ready_r;
  assign cmd.Busy      = busy_r;
  assign cmd.Done      = done_r;

  // Next-state and contact sequencing for the press/release script.
  always_comb begin
    state_nx_s   = state_r;
    contact_nx_s = contact_r;
    cyc_nx_s     = cyc_r + 1'b1;
    tick_nx_s    = tick_r;
    tog_nx_s     = tog_r;
    accept_s     = 1'b0;
    case (state_r)
      IDLE: begin
        contact_nx_s = 1'b0;
        cyc_nx_s     = '0;
        if (cmd.Cmd_Valid && ready_r) begin
          accept_s     = 1'b1;
          state_nx_s   = BOUNCE_P;
          contact_nx_s = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BOUNCE_P, BOUNCE_R: begin
        // The phase ends one bounce period after the last inversion.
        if (BOUNCE_TOGGLES == 0 || (cyc_r == BOUNCE_LAST && tog_r == TOG_N)) begin
          state_nx_s   = (state_r == BOUNCE_P) ? HOLD : GAP;
          contact_nx_s = (state_r == BOUNCE_P);
        end else if (cyc_r == BOUNCE_LAST) begin
          cyc_nx_s     = '0;
          contact_nx_s = ~contact_r;
          tog_nx_s     = tog_r + 1'b1;
        end else begin
          contact_nx_s = contact_r;
        end
      end
      HOLD: begin
        contact_nx_s = 1'b1;
        if (cyc_r == TICK_LAST) begin
          cyc_nx_s = '0;
          if (tick_r == hold_last_r) begin
            state_nx_s   = BOUNCE_R;
            contact_nx_s = 1'b0;
          end else begin
            tick_nx_s = tick_r + 16'd1;
          end
        end else begin
          tick_nx_s = tick_r;
        end
      end
      GAP: begin
        contact_nx_s = 1'b0;
        if (cyc_r == TICK_LAST) begin
          cyc_nx_s = '0;
          if (tick_r == GAP_LAST) begin
            state_nx_s = IDLE;
          end else begin
            tick_nx_s = tick_r + 16'd1;
          end
        end else begin
          tick_nx_s = tick_r;
        end
      end
      default: begin
        state_nx_s   = IDLE;
        contact_nx_s = 1'b0;
      end
    endcase
  end

  // State, counters, latched command and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= IDLE;
      contact_r   <= 1'b0;
      cyc_r       <= '0;
      tick_r      <= 16'd0;
      tog_r       <= '0;
      row_r       <= 2'd0;
      col_r       <= 2'd0;
      hold_last_r <= 16'd0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      contact_r <= contact_nx_s;
      if (state_nx_s != state_r) begin
        cyc_r  <= '0;
        tick_r <= 16'd0;
        tog_r  <= '0;
      end else begin
        cyc_r  <= cyc_nx_s;
        tick_r <= tick_nx_s;
        tog_r  <= tog_nx_s;
      end
      if (accept_s) begin
        {row_r, col_r} <= key_pos(cmd.Cmd_Key);
        hold_last_r    <= (cmd.Cmd_Hold == 16'd0) ? 16'd0 : cmd.Cmd_Hold - 16'd1;
      end
      ready_r <= (state_nx_s == IDLE);
      busy_r  <= (state_nx_s != IDLE);
      done_r  <= (state_r == GAP) && (state_nx_s == IDLE);
    end
  end

  // Closed contact pulls its row low only while its column is driven low.
  always_comb begin
    Key_Board_Row_o = 4'b1111;
    if (contact_r && !Key_Board_Col_i[col_r]) begin
      Key_Board_Row_o[row_r] = 1'b0;
    end else begin
      Key_Board_Row_o = 4'b1111;
    end
  end

endmodule
